// File: rtl/bcd_display_pkg.sv
// Shared types and seven-segment constants for the two-digit BCD display scanner.
package bcd_display_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SCAN_TENS = 2'd1,
      SCAN_ONES = 2'd2
   } state_e;

   // Segment order {g,f,e,d,c,b,a}, active-high
   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_E     = 7'b1111001;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/bcd_seg7_decoder.sv
// Combinational BCD digit to seven-segment pattern; non-decimal codes show "E".
module bcd_seg7_decoder
   import bcd_display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_E;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_E;
      endcase
   end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed two-digit seven-segment driver; new values are taken only at frame end
// so a displayed digit pair never tears.
module bcd_display_scanner
   import bcd_display_pkg::*;
#(
   parameter int unsigned REFRESH_CYCLES     = 4,
   parameter bit          BLANK_LEADING_ZERO = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_val,
   output logic       in_rdy,
   input  logic [3:0] in_tens,
   input  logic [3:0] in_ones,
   input  logic       clear,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       busy
);

   localparam logic [7:0] LAST_CNT = 8'(REFRESH_CYCLES - 1);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] tens_q, tens_d;
   logic [3:0] ones_q, ones_d;
   logic       frame_end;
   logic [3:0] digit_sel;
   logic [6:0] dec_seg;

   assign frame_end = (cnt_q == LAST_CNT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tens_q  <= '0;
         ones_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      // clear wins over any handshake; held digits are intentionally kept
      if (clear) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_val) begin
                  tens_d  = in_tens;
                  ones_d  = in_ones;
                  cnt_d   = '0;
                  state_d = SCAN_TENS;
               end
            end
            SCAN_TENS: begin
               if (frame_end) begin
                  cnt_d   = '0;
                  state_d = SCAN_ONES;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            SCAN_ONES: begin
               if (frame_end) begin
                  cnt_d   = '0;
                  state_d = SCAN_TENS;
                  if (in_val) begin
                     tens_d = in_tens;
                     ones_d = in_ones;
                  end
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign digit_sel = (state_q == SCAN_TENS) ? tens_q : ones_q;

   bcd_seg7_decoder u_dec (
      .bcd (digit_sel),
      .seg (dec_seg)
   );

   always_comb begin
      seg = SEG_BLANK;
      an  = 2'b00;
      case (state_q)
         SCAN_TENS: begin
            an  = 2'b10;
            seg = (BLANK_LEADING_ZERO && (tens_q == 4'd0)) ? SEG_BLANK : dec_seg;
         end
         SCAN_ONES: begin
            an  = 2'b01;
            seg = dec_seg;
         end
         default: begin
            seg = SEG_BLANK;
            an  = 2'b00;
         end
      endcase
   end

   assign in_rdy = !clear && ((state_q == IDLE) || ((state_q == SCAN_ONES) && frame_end));
   assign busy   = (state_q != IDLE);

endmodule
